// File: rtl/src_property_mem_responder_pkg.sv
// Shared types for the source-property read path.
// Used by ReadSrcProperty and the property memory responder.
package src_property_mem_responder_pkg;

  localparam int PROP_WORD_W = 64;
  localparam int MEM_ADDR_W  = 32;

  typedef struct packed {
    logic                   valid;
    logic [PROP_WORD_W-1:0] data;
  } prop_rsp_t;

  typedef struct packed {
    logic                  valid;
    logic [MEM_ADDR_W-1:0] addr;
  } mem_req_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/src_property_mem_responder_if.sv
// Read request / response bundle between the read stage
// (master) and the property memory responder (slave).
interface src_property_mem_responder_if #(
  parameter int ADDR_W = 10
) ();
  import src_property_mem_responder_pkg::*;

  logic                   req_valid;
  logic [ADDR_W-1:0]      req_addr;
  logic                   ready;
  logic                   complete;
  logic [PROP_WORD_W-1:0] src_data;

  modport master (
    output req_valid,
    output req_addr,
    input  ready,
    input  complete,
    input  src_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output ready,
    output complete,
    output src_data
  );
endinterface

// File: rtl/src_property_mem_responder_delay_line.sv
// Fixed-latency shift register of {valid, data}.
// Data only advances behind a valid, so the tail holds the last word.
module prop_rsp_delay_line
  import src_property_mem_responder_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  prop_rsp_t din,
  output prop_rsp_t dout
);

  prop_rsp_t stg [LATENCY];

  // Shift valids every cycle; move data only with a valid beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0].valid <= din.valid;
      if (din.valid) begin
        stg[0].data <= din.data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        stg[i].valid <= stg[i-1].valid;
        if (stg[i-1].valid) begin
          stg[i].data <= stg[i-1].data;
        end
      end
    end
  end

  assign dout = stg[LATENCY-1];

endmodule

// File: rtl/src_property_mem_responder.sv
// Property store responder: fixed-latency reads, in-flight limit.
// Optional perf counters when PROP_RSP_PERF_EN is defined.
module src_property_mem_responder
  import src_property_mem_responder_pkg::*;
#(
  parameter  int DEPTH           = 1024,
  parameter  int LATENCY         = 4,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int AW              = $clog2(DEPTH),
  localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  src_property_mem_responder_if.slave bus,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [PROP_WORD_W-1:0] wr_data,
  output logic [OW-1:0]          outstanding
`ifdef PROP_RSP_PERF_EN
  ,
  output logic [31:0]            perf_reads,
  output logic [31:0]            perf_stalls
`endif
);

  logic [PROP_WORD_W-1:0] mem [DEPTH];
  logic                   accept;
  logic                   done;
  prop_rsp_t              head;
  prop_rsp_t              tail;

  assign bus.ready = (outstanding < OW'(MAX_OUTSTANDING));
  assign accept    = bus.req_valid & bus.ready;

  assign head.valid = accept;
  assign head.data  = mem[bus.req_addr];

  // Store write; a same-edge read already sampled the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  prop_rsp_delay_line #(
    .LATENCY (LATENCY)
  ) u_dl (
    .clk   (clk),
    .reset (reset),
    .din   (head),
    .dout  (tail)
  );

  assign done         = tail.valid;
  assign bus.complete = tail.valid;
  assign bus.src_data = tail.data;

  // In-flight count: up on accept, down on complete.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, done})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef PROP_RSP_PERF_EN
  // Saturating accept and stall counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads  <= '0;
      perf_stalls <= '0;
    end else begin
      if (accept) begin
        perf_reads <= sat_inc32(perf_reads);
      end
      if (bus.req_valid && !bus.ready) begin
        perf_stalls <= sat_inc32(perf_stalls);
      end
    end
  end
`endif

endmodule

// File: tb/tb_src_property_mem_responder.sv
// Directed bench for src_property_mem_responder.
// Two instances: default limits, and MAX_OUTSTANDING=2.
module tb_src_property_mem_responder;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [2:0]  m_out;
  logic [1:0]  t_out;

  int n_cmp = 0;
  int n_err = 0;

  src_property_mem_responder_if #(.ADDR_W(10)) m ();
  src_property_mem_responder_if #(.ADDR_W(10)) t ();

`ifdef PROP_RSP_PERF_EN
  logic [31:0] m_reads, m_stalls, t_reads, t_stalls;
`endif

  src_property_mem_responder #(
    .DEPTH(1024), .LATENCY(4), .MAX_OUTSTANDING(4)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (m.slave),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .outstanding (m_out)
`ifdef PROP_RSP_PERF_EN
    ,
    .perf_reads  (m_reads),
    .perf_stalls (m_stalls)
`endif
  );

  src_property_mem_responder #(
    .DEPTH(1024), .LATENCY(4), .MAX_OUTSTANDING(2)
  ) u_thr (
    .clk         (clk),
    .reset       (reset),
    .bus         (t.slave),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .outstanding (t_out)
`ifdef PROP_RSP_PERF_EN
    ,
    .perf_reads  (t_reads),
    .perf_stalls (t_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [63:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [63:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Single read on the main instance; response must land after 4 cycles.
  task automatic read_one(input string name,
                          input logic [9:0] a,
                          input logic [63:0] exp);
    m.req_valid = 1'b1;
    m.req_addr  = a;
    tick();
    m.req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk({name, "_cmp"}, 64'(m.complete), 64'(k == 4));
      if (k == 4) chk({name, "_data"}, m.src_data, exp);
      tick();
    end
  endtask

  vec_t vecs [4];
  logic exp_rdy [13];
  logic [1:0] exp_tout [13];
  int   p;
  int   nrsp;

  initial begin
    vecs[0] = '{10'd0, 64'd100};
    vecs[1] = '{10'd1, 64'd101};
    vecs[2] = '{10'd2, 64'd102};
    vecs[3] = '{10'd3, 64'd103};
    exp_rdy  = '{1,1,0,0,0,1,1,0,0,0,1,1,1};
    exp_tout = '{0,1,2,2,2,1,1,2,2,2,1,0,0};

    reset       = 1'b1;
    m.req_valid = 1'b0;
    m.req_addr  = '0;
    t.req_valid = 1'b0;
    t.req_addr  = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    tick();
    tick();
    reset = 1'b0;

    @(negedge clk);
    chk("rst_ready", 64'(m.ready), 64'd1);
    chk("rst_complete", 64'(m.complete), 64'd0);
    chk("rst_src_data", m.src_data, 64'd0);
    chk("rst_outstanding", 64'(m_out), 64'd0);
    chk("rst_thr_ready", 64'(t.ready), 64'd1);

    wr(10'd5, 64'h0000_0000_DEAD_BEEF);
    for (int i = 0; i < 4; i++) wr(10'(i), 64'(100 + i));
    wr(10'd7, 64'd1);

    // Single read with outstanding trace 0 -> 1 -> 0.
    m.req_valid = 1'b1;
    m.req_addr  = 10'd5;
    @(negedge clk);
    chk("pre_ready", 64'(m.ready), 64'd1);
    chk("pre_out0", 64'(m_out), 64'd0);
    tick();
    m.req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("pre_complete", 64'(m.complete), 64'(k == 4));
      chk("pre_out", 64'(m_out), 64'(k <= 4));
      if (k == 4) chk("pre_data", m.src_data, 64'hDEAD_BEEF);
      tick();
    end

    // Back-to-back table reads.
    for (int i = 0; i < 4; i++) begin
      m.req_valid = 1'b1;
      m.req_addr  = vecs[i].addr;
      @(negedge clk);
      chk("b2b_ready", 64'(m.ready), 64'd1);
      tick();
    end
    m.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_complete", 64'(m.complete), 64'd1);
      chk("b2b_data", m.src_data, vecs[i].exp);
      tick();
    end
    @(negedge clk);
    chk("b2b_idle", 64'(m.complete), 64'd0);
    chk("b2b_hold", m.src_data, 64'd103);
    tick();

    // Same-edge read and write of addr 7.
    m.req_valid = 1'b1;
    m.req_addr  = 10'd7;
    wr_en       = 1'b1;
    wr_addr     = 10'd7;
    wr_data     = 64'd2;
    tick();
    wr_en = 1'b0;
    tick();
    m.req_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("col_cmp_old", 64'(m.complete), 64'd1);
    chk("col_old", m.src_data, 64'd1);
    tick();
    @(negedge clk);
    chk("col_cmp_new", 64'(m.complete), 64'd1);
    chk("col_new", m.src_data, 64'd2);
    tick();

    // Reset with three reads in flight.
    for (int i = 0; i < 3; i++) begin
      m.req_valid = 1'b1;
      m.req_addr  = 10'(i);
      tick();
    end
    m.req_valid = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    chk("mid_out3", 64'(m_out), 64'd3);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mid_no_cmp", 64'(m.complete), 64'd0);
      chk("mid_out0", 64'(m_out), 64'd0);
      chk("mid_ready", 64'(m.ready), 64'd1);
      tick();
    end
    read_one("mid_store", 10'd5, 64'hDEAD_BEEF);

    // Throttle on the MAX_OUTSTANDING=2 instance; requester holds.
    p    = 0;
    nrsp = 0;
    for (int k = 0; k < 13; k++) begin
      t.req_valid = (p < 4);
      t.req_addr  = 10'(p);
      @(negedge clk);
      chk("thr_ready", 64'(t.ready), 64'(exp_rdy[k]));
      chk("thr_out", 64'(t_out), 64'(exp_tout[k]));
      chk("thr_complete", 64'(t.complete),
          64'(k == 4 || k == 5 || k == 9 || k == 10));
      if (t.complete) begin
        chk("thr_data", t.src_data, 64'(100 + nrsp));
        nrsp++;
      end
`ifdef PROP_RSP_PERF_EN
      if (k == 4) chk("perf_stalls_k4", 64'(t_stalls), 64'd2);
`endif
      if (t.req_valid && t.ready) p++;
      tick();
    end
    t.req_valid = 1'b0;
    chk("thr_accepts", 64'(p), 64'd4);
    chk("thr_responses", 64'(nrsp), 64'd4);
`ifdef PROP_RSP_PERF_EN
    @(negedge clk);
    chk("perf_reads", 64'(t_reads), 64'd4);
    chk("perf_stalls", 64'(t_stalls), 64'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
